// File: rtl/status_unit.sv
// ---------------------------------------------------------------------------
// status_unit : NZCV status register with in-flight S-writer tracking,
//               EX-flag forwarding and flag-hazard stall for the ID stage.
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module status_unit #(
  parameter int LAT    = 1,
  parameter bit FWD_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [3:0] id_cond,
  input  logic       id_s,
  input  logic       freeze,
  input  logic       flush,
  input  logic [3:0] ex_flags,
  output logic [3:0] status_out,
  output logic       flag_stall,
  output logic [3:0] sr
);

  localparam logic [3:0] C_COND_AL = 4'b1110;
  localparam logic [3:0] C_COND_NV = 4'b1111;

  logic [LAT-1:0] pend_q, pend_d;
  logic [3:0]     sr_q, sr_d;
  logic           needs_cond;
  logic           older_busy;
  logic           tail_busy;
  logic           issue;

  assign needs_cond = id_valid & (id_cond != C_COND_AL) & (id_cond != C_COND_NV);
  assign tail_busy  = pend_q[LAT-1];

  // pend[0] is the youngest issued writer; pend[LAT-1] sits in the EX commit slot
  generate
    if (LAT == 1) begin : g_lat_one
      assign older_busy = 1'b0;
      assign pend_d     = issue;
    end else begin : g_lat_multi
      assign older_busy = |pend_q[LAT-2:0];
      assign pend_d     = {pend_q[LAT-2:0], issue};
    end
  endgenerate

  generate
    if (FWD_EN) begin : g_fwd
      assign flag_stall = needs_cond & older_busy;
      assign status_out = tail_busy ? ex_flags : sr_q;
    end else begin : g_nofwd
      assign flag_stall = needs_cond & (older_busy | tail_busy);
      assign status_out = sr_q;
    end
  endgenerate

  assign issue = id_valid & id_s & ~flush & ~freeze & ~flag_stall;
  assign sr_d  = tail_busy ? ex_flags : sr_q;

  // The pipe drains unconditionally; stalls only stop new writers entering
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      sr_q   <= 4'b0000;
    end else begin
      pend_q <= pend_d;
      sr_q   <= sr_d;
    end
  end

  assign sr = sr_q;

endmodule

`default_nettype wire

// File: tb/tb_status_unit.sv
// ---------------------------------------------------------------------------
// tb_status_unit : directed self-checking bench for status_unit over four
//                  LAT/FWD_EN configurations sharing one stimulus stream.
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_status_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [3:0] cond = 4'b1110;
  logic       s = 1'b0;
  logic       frz = 1'b0;
  logic       fl = 1'b0;
  logic [3:0] exf = 4'b0000;

  logic [3:0] so1, so2, so0, so3;
  logic [3:0] sr1, sr2, sr0, sr3;
  logic       st1, st2, st0, st3;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  // u1: LAT=1 fwd, u2: LAT=2 fwd, u0: LAT=1 no-fwd, u3: LAT=3 no-fwd
  status_unit #(.LAT(1), .FWD_EN(1'b1)) u1 (
    .clk(clk), .rst(rst), .id_valid(valid), .id_cond(cond), .id_s(s),
    .freeze(frz), .flush(fl), .ex_flags(exf),
    .status_out(so1), .flag_stall(st1), .sr(sr1));
  status_unit #(.LAT(2), .FWD_EN(1'b1)) u2 (
    .clk(clk), .rst(rst), .id_valid(valid), .id_cond(cond), .id_s(s),
    .freeze(frz), .flush(fl), .ex_flags(exf),
    .status_out(so2), .flag_stall(st2), .sr(sr2));
  status_unit #(.LAT(1), .FWD_EN(1'b0)) u0 (
    .clk(clk), .rst(rst), .id_valid(valid), .id_cond(cond), .id_s(s),
    .freeze(frz), .flush(fl), .ex_flags(exf),
    .status_out(so0), .flag_stall(st0), .sr(sr0));
  status_unit #(.LAT(3), .FWD_EN(1'b0)) u3 (
    .clk(clk), .rst(rst), .id_valid(valid), .id_cond(cond), .id_s(s),
    .freeze(frz), .flush(fl), .ex_flags(exf),
    .status_out(so3), .flag_stall(st3), .sr(sr3));

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic sb,
                       input logic fz, input logic f, input logic [3:0] e);
    valid = v; cond = c; s = sb; frz = fz; fl = f; exf = e;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, 4'b0000);
    rst = 1'b1;
    edge_step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    vectors++;
    if ({sr1, sr2, sr0, sr3} !== 16'h0000) begin
      errors++; $display("FAIL reset_sr got=%h exp=0000", {sr1, sr2, sr0, sr3});
    end
    vectors++;
    if ({st1, st2, st0, st3} !== 4'b0000 || {so1, so2, so0, so3} !== 16'h0000) begin
      errors++; $display("FAIL reset_out st=%b so=%h exp st=0000 so=0000",
                         {st1, st2, st0, st3}, {so1, so2, so0, so3});
    end
    rst = 1'b0;
    // load one writer into every pipe, then reset asynchronously mid-flight
    drive(1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 4'b0000);
    edge_step();
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b1010);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({st1, st2, st0, st3} !== 4'b0000 || so1 !== 4'b0000 || sr1 !== 4'b0000) begin
      errors++; $display("FAIL reset_async st=%b so1=%h sr1=%h exp st=0000 so1=0 sr1=0",
                         {st1, st2, st0, st3}, so1, sr1);
    end
    @(negedge clk);
    rst = 1'b0;
    edge_step();
    vectors++;
    if ({sr1, sr2, sr0, sr3} !== 16'h0000) begin
      errors++; $display("FAIL reset_nocommit got=%h exp=0000", {sr1, sr2, sr0, sr3});
    end
    drive(1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 4'b0000);
    vectors++;
    if ({st1, st2, st0, st3} !== 4'b0000) begin
      errors++; $display("FAIL reset_al st=%b exp=0000", {st1, st2, st0, st3});
    end
  endtask

  task automatic test_forwarding();
    do_reset();
    drive(1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 4'b0000);
    edge_step();
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0100);
    vectors++;
    if ({st1, st2, st0, st3} !== 4'b0111) begin
      errors++; $display("FAIL fwd_c1_stall got=%b exp=0111", {st1, st2, st0, st3});
    end
    vectors++;
    if (so1 !== 4'b0100 || so0 !== 4'b0000) begin
      errors++; $display("FAIL fwd_c1_status so1=%h so0=%h exp 4 0", so1, so0);
    end
    edge_step();
    vectors++;
    if ({sr1, sr2, sr0, sr3} !== 16'h4040) begin
      errors++; $display("FAIL fwd_c1_sr got=%h exp=4040", {sr1, sr2, sr0, sr3});
    end
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0110);
    vectors++;
    if ({st1, st2, st0, st3} !== 4'b0001 || {so1, so2, so0} !== 12'h464) begin
      errors++; $display("FAIL fwd_c2 st=%b so=%h exp st=0001 so=464",
                         {st1, st2, st0, st3}, {so1, so2, so0});
    end
    edge_step();
    vectors++;
    if ({sr1, sr2, sr0, sr3} !== 16'h4640) begin
      errors++; $display("FAIL fwd_c2_sr got=%h exp=4640", {sr1, sr2, sr0, sr3});
    end
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0011);
    vectors++;
    if (st3 !== 1'b1 || so3 !== 4'b0000) begin
      errors++; $display("FAIL nofwd_tail st3=%b so3=%h exp 1 0", st3, so3);
    end
    edge_step();
    vectors++;
    if (sr3 !== 4'b0011 || st3 !== 1'b0 || so3 !== 4'b0011) begin
      errors++; $display("FAIL nofwd_commit sr3=%h st3=%b so3=%h exp 3 0 3", sr3, st3, so3);
    end
  endtask

  task automatic test_flush_freeze();
    do_reset();
    drive(1'b1, 4'b1110, 1'b1, 1'b0, 1'b1, 4'b0000);
    edge_step();
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b1111);
    vectors++;
    if ({st1, st2, st0, st3} !== 4'b0000 || so1 !== 4'b0000) begin
      errors++; $display("FAIL flush_noissue st=%b so1=%h exp 0000 0", {st1, st2, st0, st3}, so1);
    end
    edge_step();
    vectors++;
    if ({sr1, sr2, sr0, sr3} !== 16'h0000) begin
      errors++; $display("FAIL flush_sr got=%h exp=0000", {sr1, sr2, sr0, sr3});
    end
    // one real writer, then a frozen (and flushed) S instruction behind it
    drive(1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 4'b0000);
    edge_step();
    drive(1'b1, 4'b1110, 1'b1, 1'b1, 1'b1, 4'b1001);
    edge_step();
    vectors++;
    if ({sr1, sr0} !== 8'h99) begin
      errors++; $display("FAIL freeze_commit sr1=%h sr0=%h exp 9 9", sr1, sr0);
    end
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0101);
    vectors++;
    if ({st1, st2, st0, st3} !== 4'b0001 || {so1, so2, so0} !== 12'h959) begin
      errors++; $display("FAIL freeze_drain st=%b so=%h exp st=0001 so=959",
                         {st1, st2, st0, st3}, {so1, so2, so0});
    end
    edge_step();
    vectors++;
    if ({sr1, sr2, sr0} !== 12'h959) begin
      errors++; $display("FAIL freeze_sr got=%h exp=959", {sr1, sr2, sr0});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 4'b0001);
    edge_step();
    drive(1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 4'b1000);
    edge_step();
    vectors++;
    if ({sr1, sr2} !== 8'h80) begin
      errors++; $display("FAIL b2b_e2 got=%h exp=80", {sr1, sr2});
    end
    drive(1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, 4'b0010);
    edge_step();
    vectors++;
    if ({sr1, sr2} !== 8'h22) begin
      errors++; $display("FAIL b2b_e3 got=%h exp=22", {sr1, sr2});
    end
    drive(1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, 4'b0100);
    edge_step();
    vectors++;
    if ({sr1, sr2} !== 8'h24) begin
      errors++; $display("FAIL b2b_e4 got=%h exp=24", {sr1, sr2});
    end
  endtask

  task automatic test_al_nostall();
    do_reset();
    drive(1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 4'b0000);
    edge_step();
    drive(1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 4'b0000);
    vectors++;
    if ({st1, st2, st0, st3} !== 4'b0000) begin
      errors++; $display("FAIL al_1110 st=%b exp=0000", {st1, st2, st0, st3});
    end
    drive(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000);
    vectors++;
    if ({st1, st2, st0, st3} !== 4'b0000) begin
      errors++; $display("FAIL al_1111 st=%b exp=0000", {st1, st2, st0, st3});
    end
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    vectors++;
    if ({st1, st2, st0, st3} !== 4'b0000) begin
      errors++; $display("FAIL invalid_nostall st=%b exp=0000", {st1, st2, st0, st3});
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_forwarding();
    test_flush_freeze();
    test_back_to_back();
    test_al_nostall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
